// File: rtl/aes_pkg.sv
// Shared constants and the sequencer state type for the AES-128 encrypt scheduler.
package aes_pkg;
    localparam int AES_BLOCK_W  = 128;
    localparam int AES_PIPE_LAT = 11;
    localparam int AES_KEY_LAT  = 12;

    typedef enum logic [1:0] {
        NOKEY  = 2'd0,
        KEYEXP = 2'd1,
        READY  = 2'd2,
        DRAIN  = 2'd3
    } sched_state_t;
endpackage

// File: rtl/aes_enc_sched_if.sv
// Host-side key / plaintext / ciphertext handshakes of the AES scheduler.
interface aes_enc_sched_if import aes_pkg::*; #(
    parameter int BLOCK_W = AES_BLOCK_W,
    parameter int TAG_W   = 4
);
    logic               key_valid;
    logic               key_ready;
    logic [BLOCK_W-1:0] key_in;
    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] in_data;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] out_data;
    logic [TAG_W-1:0]   out_tag;

    modport master (
        output key_valid, key_in, in_valid, in_data, in_tag, out_ready,
        input  key_ready, in_ready, out_valid, out_data, out_tag
    );
    modport slave (
        input  key_valid, key_in, in_valid, in_data, in_tag, out_ready,
        output key_ready, in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/aes_out_fifo.sv
// First-word-fall-through FIFO; push and pop may coincide at any occupancy.
module aes_out_fifo #(
    parameter int WIDTH = 132,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_pop;

    // A pop on an empty FIFO is ignored so an empty+push cycle is a plain write.
    assign do_pop = pop && !empty;
    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign rdata  = mem[rd_ptr];

    // Storage array; no reset needed, occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/aes_enc_sched.sv
// Sequencer around the pipelined AES-128 core: key load/expansion timing,
// credit-gated plaintext admission, tag pipe and ciphertext output FIFO.
// FIFO_DEPTH must be a power of two and at least PIPE_LAT.
module aes_enc_sched import aes_pkg::*; #(
    parameter int BLOCK_W    = AES_BLOCK_W,
    parameter int TAG_W      = 4,
    parameter int PIPE_LAT   = AES_PIPE_LAT,
    parameter int KEY_LAT    = AES_KEY_LAT,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    aes_enc_sched_if.slave     host,
    output logic [BLOCK_W-1:0] core_key,
    output logic               core_fsm_en,
    output logic               core_enable,
    output logic [BLOCK_W-1:0] core_in,
    input  logic [BLOCK_W-1:0] core_out,
    output logic               busy
);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int KW = $clog2(KEY_LAT);

    sched_state_t                   state, state_nx;
    logic [KW-1:0]                  kc;
    logic [CW-1:0]                  pipe_cnt, fifo_cnt;
    logic                           credit_ok, key_load;
    logic [PIPE_LAT-1:0]            vld_pipe;
    logic [PIPE_LAT-1:0][TAG_W-1:0] tag_pipe;
    logic                           fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [BLOCK_W+TAG_W-1:0]       fifo_rdata;

    // Every block in the pipe already owns a FIFO slot, so the core never
    // needs to stall. Registered counts only: a same-cycle pop is not credited.
    assign credit_ok = ({1'b0, pipe_cnt} + {1'b0, fifo_cnt}) < (CW+1)'(FIFO_DEPTH);
    assign key_load  = host.key_valid && host.key_ready;

    // Next state and handshake readies; key_valid blocks admission so a
    // pending rekey can drain the pipe.
    always_comb begin
        state_nx       = state;
        host.key_ready = 1'b0;
        host.in_ready  = 1'b0;
        core_fsm_en    = 1'b0;
        case (state)
            NOKEY: begin
                host.key_ready = 1'b1;
                if (host.key_valid) state_nx = KEYEXP;
            end
            KEYEXP: begin
                core_fsm_en = 1'b1;
                if (kc == KW'(KEY_LAT-1)) state_nx = READY;
            end
            READY: begin
                host.key_ready = (pipe_cnt == '0);
                host.in_ready  = credit_ok && !host.key_valid;
                if (host.key_valid) state_nx = (pipe_cnt == '0) ? KEYEXP : DRAIN;
            end
            DRAIN: begin
                host.key_ready = (pipe_cnt == '0);
                if (!host.key_valid)      state_nx = READY;
                else if (pipe_cnt == '0)  state_nx = KEYEXP;
            end
            default: state_nx = NOKEY;
        endcase
    end

    // State, key register and expansion counter. The key only loads when the
    // pipe is empty, so in-flight blocks always finish under the old key.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= NOKEY;
            kc       <= '0;
            core_key <= '0;
        end else begin
            state <= state_nx;
            if (key_load) begin
                core_key <= host.key_in;
                kc       <= '0;
            end else if (state == KEYEXP) begin
                kc <= kc + 1'b1;
            end
        end
    end

    assign core_enable = host.in_valid && host.in_ready;
    assign core_in     = host.in_data;

    // Tag/valid pipe mirroring the core latency, plus in-flight count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
            pipe_cnt <= '0;
        end else begin
            vld_pipe <= {vld_pipe[PIPE_LAT-2:0], core_enable};
            tag_pipe <= {tag_pipe[PIPE_LAT-2:0], host.in_tag};
            case ({core_enable, vld_pipe[PIPE_LAT-1]})
                2'b10:   pipe_cnt <= pipe_cnt + 1'b1;
                2'b01:   pipe_cnt <= pipe_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    assign fifo_push = vld_pipe[PIPE_LAT-1];
    assign fifo_pop  = host.out_ready && !fifo_empty;

    aes_out_fifo #(.WIDTH(BLOCK_W+TAG_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata ({core_out, tag_pipe[PIPE_LAT-1]}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign host.out_valid                = !fifo_empty;
    assign {host.out_data, host.out_tag} = fifo_rdata;

    // NOKEY is idle; only key expansion, a pending rekey or live blocks count.
    assign busy = (state == KEYEXP) || (state == DRAIN) || (pipe_cnt != '0);

    // Credits guarantee an exiting block always finds room.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(fifo_push && fifo_full && !fifo_pop));
endmodule

// File: tb/tb_aes_enc_sched.sv
// Directed bench for aes_enc_sched with a behavioural pipelined AES-128 core.
module tb_aes_enc_sched;
    import aes_pkg::*;
    localparam int BW = 128;
    localparam int TW = 4;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [BW-1:0] core_key, core_in, core_out;
    logic core_fsm_en, core_enable, busy;
    int errs = 0, nchk = 0, cyc = 0;

    aes_enc_sched_if #(.BLOCK_W(BW), .TAG_W(TW)) bus();

    aes_enc_sched #(.BLOCK_W(BW), .TAG_W(TW), .PIPE_LAT(11), .KEY_LAT(12), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .host(bus),
        .core_key(core_key), .core_fsm_en(core_fsm_en), .core_enable(core_enable),
        .core_in(core_in), .core_out(core_out), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- AES-128 reference ----------------
    logic [7:0] sb [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0; x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc, a0, a1, a2, a3;
        logic [7:0]  b [16];
        logic [7:0]  n [16];
        logic [127:0] st;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        st = pt ^ {w[0], w[1], w[2], w[3]};
        for (int r = 1; r <= 10; r++) begin
            for (int k = 0; k < 16; k++) b[k] = sb[st[127-8*k -: 8]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) n[c*4+rr] = b[((c+rr)%4)*4+rr];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = n[c*4]; a1 = n[c*4+1]; a2 = n[c*4+2]; a3 = n[c*4+3];
                    n[c*4]   = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
                    n[c*4+1] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
                    n[c*4+2] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
                    n[c*4+3] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
                end
            end
            for (int k = 0; k < 16; k++) st[127-8*k -: 8] = n[k];
            st ^= {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return st;
    endfunction

    // Core model: round keys captured while fsm_en is high, 11-cycle result pipe.
    logic [127:0] mkey;
    logic [127:0] csr [11];
    always @(posedge clk) begin
        if (!rst) begin
            mkey <= '0;
            for (int i = 0; i < 11; i++) csr[i] <= '0;
        end else begin
            if (core_fsm_en) mkey <= core_key;
            csr[0] <= core_enable ? aes_enc(mkey, core_in) : '0;
            for (int i = 1; i < 11; i++) csr[i] <= csr[i-1];
        end
    end
    assign core_out = csr[10];

    // Output monitor, sampled mid-cycle.
    logic [127:0] oq_d [$];
    logic [TW-1:0] oq_t [$];
    int oq_c [$];
    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready) begin
            oq_d.push_back(bus.out_data);
            oq_t.push_back(bus.out_tag);
            oq_c.push_back(cyc);
        end
    end

    function automatic logic [127:0] pat(input int i);
        return {32'(i), 32'hdeadbeef ^ 32'(i*7), 64'h0123456789abcdef + 64'(i)};
    endfunction

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic qclr(); oq_d.delete(); oq_t.delete(); oq_c.delete(); endtask
    task automatic idle();
        bus.key_valid = 0; bus.key_in = '0; bus.in_valid = 0;
        bus.in_data = '0; bus.in_tag = '0; bus.out_ready = 1;
    endtask
    task automatic wait_out(input int n);
        for (int k = 0; k < 200 && oq_d.size() < n; k++) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle(); rst = 0; tick(); tick();
        nchk++; if (bus.key_ready !== 1'b1) begin errs++; $display("FAIL rst_key_ready got=%b exp=1", bus.key_ready); end
        nchk++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
        nchk++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        nchk++; if ({core_fsm_en, core_enable, busy} !== 3'b000) begin errs++; $display("FAIL rst_ctl got=%b exp=000", {core_fsm_en, core_enable, busy}); end
        nchk++; if (core_key !== '0) begin errs++; $display("FAIL rst_core_key got=%h exp=0", core_key); end
        rst = 1; tick();
        nchk++; if (dut.state !== NOKEY) begin errs++; $display("FAIL rst_state got=%0d exp=%0d", dut.state, NOKEY); end
    endtask

    task automatic test_key_load();
        int n;
        bus.key_valid = 1; bus.key_in = K1; #1;
        nchk++; if (bus.key_ready !== 1'b1) begin errs++; $display("FAIL key_ready got=%b exp=1", bus.key_ready); end
        tick(); bus.key_valid = 0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (!core_fsm_en) break;
            n++; tick();
        end
        nchk++; if (n != 12) begin errs++; $display("FAIL fsm_en_len got=%0d exp=12", n); end
        #1;
        nchk++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL post_exp_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_single();
        int t0;
        qclr(); bus.out_ready = 1;
        bus.in_valid = 1; bus.in_data = P1; bus.in_tag = 4'd3; #1;
        nchk++; if (core_enable !== 1'b1) begin errs++; $display("FAIL single_accept got=%b exp=1", core_enable); end
        t0 = cyc;
        tick(); bus.in_valid = 0;
        wait_out(1);
        nchk++; if (oq_d.size() != 1) begin errs++; $display("FAIL single_count got=%0d exp=1", oq_d.size()); end
        if (oq_d.size() >= 1) begin
            nchk++; if (oq_d[0] !== C1) begin errs++; $display("FAIL single_data got=%h exp=%h", oq_d[0], C1); end
            nchk++; if (oq_t[0] !== 4'd3) begin errs++; $display("FAIL single_tag got=%0d exp=3", oq_t[0]); end
            nchk++; if (oq_c[0] - t0 != 12) begin errs++; $display("FAIL single_latency got=%0d exp=12", oq_c[0] - t0); end
        end
    endtask

    task automatic test_back_to_back();
        int stall, bad;
        qclr(); bus.out_ready = 1; stall = 0;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1; bus.in_data = pat(i); bus.in_tag = TW'(i); #1;
            if (!bus.in_ready) stall++;
            tick();
        end
        bus.in_valid = 0;
        nchk++; if (stall != 0) begin errs++; $display("FAIL b2b_stalls got=%0d exp=0", stall); end
        wait_out(20);
        nchk++; if (oq_d.size() != 20) begin errs++; $display("FAIL b2b_count got=%0d exp=20", oq_d.size()); end
        bad = 0;
        for (int i = 0; i < oq_d.size(); i++)
            if (oq_d[i] !== aes_enc(K1, pat(i)) || oq_t[i] !== TW'(i) || oq_c[i] != oq_c[0] + i) bad++;
        nchk++; if (bad != 0) begin errs++; $display("FAIL b2b_order bad_entries got=%0d exp=0", bad); end
    endtask

    task automatic test_backpressure();
        int acc, bad;
        qclr(); bus.out_ready = 0; acc = 0;
        for (int k = 0; k < 40; k++) begin
            bus.in_valid = 1; bus.in_data = pat(100 + acc); bus.in_tag = TW'(acc); #1;
            if (bus.in_ready) acc++;
            tick();
        end
        nchk++; if (acc != 16) begin errs++; $display("FAIL bp_accepts got=%0d exp=16", acc); end
        nchk++; if ({bus.in_ready, bus.out_valid} !== 2'b01) begin errs++; $display("FAIL bp_full got=%b exp=01", {bus.in_ready, bus.out_valid}); end
        bus.out_ready = 1; #1;
        nchk++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL bp_pop_not_credited got=%b exp=0", bus.in_ready); end
        tick(); bus.in_valid = 0; #1;
        nchk++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL bp_reassert got=%b exp=1", bus.in_ready); end
        wait_out(16);
        nchk++; if (oq_d.size() != 16) begin errs++; $display("FAIL bp_count got=%0d exp=16", oq_d.size()); end
        bad = 0;
        for (int i = 0; i < oq_d.size(); i++)
            if (oq_d[i] !== aes_enc(K1, pat(100 + i)) || oq_t[i] !== TW'(i) || oq_c[i] != oq_c[0] + i) bad++;
        nchk++; if (bad != 0) begin errs++; $display("FAIL bp_order bad_entries got=%0d exp=0", bad); end
    endtask

    task automatic test_rekey();
        int leak, bad;
        logic got_kr;
        qclr(); bus.out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1; bus.in_data = pat(200 + i); bus.in_tag = TW'(5 + i); tick();
        end
        bus.key_valid = 1; bus.key_in = K2; bus.in_data = P2; bus.in_tag = 4'd10; #1;
        nchk++; if ({bus.in_ready, core_enable, bus.key_ready} !== 3'b000) begin errs++; $display("FAIL rekey_priority got=%b exp=000", {bus.in_ready, core_enable, bus.key_ready}); end
        tick();
        nchk++; if (dut.state !== DRAIN || bus.in_ready !== 1'b0) begin errs++; $display("FAIL rekey_drain state=%0d in_ready=%b exp state=%0d in_ready=0", dut.state, bus.in_ready, DRAIN); end
        leak = 0; got_kr = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.key_ready) begin got_kr = 1; break; end
            if (bus.in_ready) leak++;
            tick();
        end
        nchk++; if (!got_kr || dut.pipe_cnt != 0 || leak != 0) begin errs++; $display("FAIL rekey_key_ready got kr=%b pipe=%0d leak=%0d exp kr=1 pipe=0 leak=0", got_kr, dut.pipe_cnt, leak); end
        tick(); bus.key_valid = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.in_ready) break;
            tick();
        end
        tick(); bus.in_valid = 0;
        wait_out(6);
        nchk++; if (oq_d.size() != 6) begin errs++; $display("FAIL rekey_count got=%0d exp=6", oq_d.size()); end
        bad = 0;
        for (int i = 0; i < 5 && i < oq_d.size(); i++)
            if (oq_d[i] !== aes_enc(K1, pat(200 + i)) || oq_t[i] !== TW'(5 + i)) bad++;
        nchk++; if (bad != 0) begin errs++; $display("FAIL rekey_old_key bad_entries got=%0d exp=0", bad); end
        if (oq_d.size() >= 6) begin
            nchk++; if (oq_d[5] !== C2 || oq_t[5] !== 4'd10) begin errs++; $display("FAIL rekey_new_key got=%h/%0d exp=%h/10", oq_d[5], oq_t[5], C2); end
        end
    endtask

    task automatic test_reset_mid();
        qclr(); bus.out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1; bus.in_data = pat(300 + i); bus.in_tag = TW'(i); tick();
        end
        bus.in_valid = 0; rst = 0; tick(); rst = 1;
        nchk++; if ({bus.out_valid, bus.in_ready, busy} !== 3'b000) begin errs++; $display("FAIL mid_rst_outputs got=%b exp=000", {bus.out_valid, bus.in_ready, busy}); end
        nchk++; if (dut.state !== NOKEY) begin errs++; $display("FAIL mid_rst_state got=%0d exp=%0d", dut.state, NOKEY); end
        qclr();
        bus.key_valid = 1; bus.key_in = K2; tick(); bus.key_valid = 0;
        for (int k = 0; k < 30 && dut.state !== READY; k++) tick();
        bus.in_valid = 1; bus.in_data = P2; bus.in_tag = 4'd11; tick(); bus.in_valid = 0;
        for (int k = 0; k < 40; k++) tick();
        nchk++; if (oq_d.size() != 1) begin errs++; $display("FAIL mid_rst_stale count got=%0d exp=1", oq_d.size()); end
        if (oq_d.size() >= 1) begin
            nchk++; if (oq_d[0] !== C2 || oq_t[0] !== 4'd11) begin errs++; $display("FAIL mid_rst_data got=%h/%0d exp=%h/11", oq_d[0], oq_t[0], C2); end
        end
    endtask

    initial begin
        logic [7:0] inv, s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h01;
            if (a == 0) inv = 8'h00;
            else for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(a));
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[a] = s;
        end
        test_reset();
        test_key_load();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_rekey();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errs, nchk);
        $fatal(1);
    end
endmodule
